// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage types: writeback selects,
// FSM encoding and error-flag bit positions.
package mem_stage_pkg;

  localparam logic [2:0] WSEL_ALU  = 3'd0;
  localparam logic [2:0] WSEL_RAM  = 3'd1;
  localparam logic [2:0] WSEL_LINK = 3'd2;

  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_MISALIGN = 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for ram_ack and
// flags the last permitted wait cycle.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic in_wait,
  input  logic ram_ack,
  output logic timeout_hit
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= 8'd0;
    end else if (!in_wait) begin
      count <= 8'd0;
    end else begin
      count <= count + 8'd1;
    end
  end

  assign timeout_hit = in_wait & ~ram_ack &
                       (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-RAM handshake with
// stall, timeout abort and misalignment trap.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_out,
  input  logic [2:0]  ex_rf_wsel,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_rdata2,
  input  logic        ex_ram_we,
  input  logic        ex_rf_nwe,
  input  logic        ex_is_ram,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_ack,
  input  logic [31:0] ram_rdata,
  output logic        stall,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_wdata,
  output logic [4:0]  mem_rd,
  output logic        mem_rf_nwe,
  output logic [1:0]  mem_err
);

  state_e      state;
  state_e      state_nx;
  logic        access_ok;
  logic        misalign;
  logic        timeout_hit;
  logic [31:0] wb_data;
  logic [1:0]  err_nx;

  assign access_ok = ex_is_ram & ~|ex_alu_out[1:0];
  assign misalign  = ex_is_ram & |ex_alu_out[1:0];

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk         (clk),
    .resetn      (resetn),
    .in_wait     (state == WAIT),
    .ram_ack     (ram_ack),
    .timeout_hit (timeout_hit)
  );

  assign ram_addr  = {ex_alu_out[31:2], 2'b00};
  assign ram_wdata = ex_rdata2;
  assign ram_we    = ex_ram_we & ram_req;
  assign stall     = ram_req & ~ram_ack & ~timeout_hit;

  always_comb begin
    ram_req  = 1'b0;
    state_nx = state;
    unique case (state)
      IDLE: begin
        ram_req = access_ok;
        if (ram_req && !ram_ack) state_nx = WAIT;
      end
      WAIT: begin
        ram_req = access_ok;
        if (ram_ack || timeout_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wb_data = ex_alu_out;
    case (ex_rf_wsel)
      WSEL_RAM:  wb_data = ram_rdata;
      WSEL_LINK: wb_data = ex_pc + 32'd8;
      default:   wb_data = ex_alu_out;
    endcase
  end

  // ack beats timeout: timeout_hit is already gated by ~ram_ack
  always_comb begin
    err_nx               = 2'b00;
    err_nx[ERR_TIMEOUT]  = timeout_hit;
    err_nx[ERR_MISALIGN] = misalign;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      mem_pc     <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_rd     <= 5'd0;
      mem_rf_nwe <= 1'b0;
      mem_err    <= 2'b00;
    end else begin
      state <= state_nx;
      if (stall) begin
        mem_rf_nwe <= 1'b0;
        mem_err    <= 2'b00;
      end else begin
        mem_pc     <= ex_pc;
        mem_rd     <= ex_rd;
        mem_wdata  <= wb_data;
        mem_rf_nwe <= ex_rf_nwe & ~misalign & ~timeout_hit;
        mem_err    <= err_nx;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage
// (TIMEOUT=4).
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] ex_pc;
  logic [31:0] ex_alu_out;
  logic [2:0]  ex_rf_wsel;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rdata2;
  logic        ex_ram_we;
  logic        ex_rf_nwe;
  logic        ex_is_ram;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ack;
  logic [31:0] ram_rdata;
  logic        stall;
  logic [31:0] mem_pc;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_rd;
  logic        mem_rf_nwe;
  logic [1:0]  mem_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ex_pc      (ex_pc),
    .ex_alu_out (ex_alu_out),
    .ex_rf_wsel (ex_rf_wsel),
    .ex_rd      (ex_rd),
    .ex_rdata2  (ex_rdata2),
    .ex_ram_we  (ex_ram_we),
    .ex_rf_nwe  (ex_rf_nwe),
    .ex_is_ram  (ex_is_ram),
    .ram_req    (ram_req),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_ack    (ram_ack),
    .ram_rdata  (ram_rdata),
    .stall      (stall),
    .mem_pc     (mem_pc),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_rf_nwe (mem_rf_nwe),
    .mem_err    (mem_err)
  );

  task automatic zero_inputs();
    ex_pc      = 32'd0;
    ex_alu_out = 32'd0;
    ex_rf_wsel = 3'd0;
    ex_rd      = 5'd0;
    ex_rdata2  = 32'd0;
    ex_ram_we  = 1'b0;
    ex_rf_nwe  = 1'b0;
    ex_is_ram  = 1'b0;
    ram_ack    = 1'b0;
    ram_rdata  = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    zero_inputs();
    tick();
    tick();
    checks++;
    if ({mem_pc, mem_wdata, mem_rd, mem_rf_nwe, mem_err} !== 72'd0) begin
      errors++;
      $display("FAIL reset_regs: got pc=%h wd=%h rd=%0d nwe=%b err=%b, want all 0",
               mem_pc, mem_wdata, mem_rd, mem_rf_nwe, mem_err);
    end
    checks++;
    if (ram_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb: got req=%b stall=%b, want 0 0", ram_req, stall);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    zero_inputs();
    ex_pc = 32'h40; ex_alu_out = 32'h1234; ex_rd = 5'd5; ex_rf_nwe = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || ram_req !== 1'b0) begin
      errors++;
      $display("FAIL alu_comb: got stall=%b req=%b, want 0 0", stall, ram_req);
    end
    tick();
    checks++;
    if (mem_wdata !== 32'h1234 || mem_pc !== 32'h40 || mem_rd !== 5'd5 ||
        mem_rf_nwe !== 1'b1 || mem_err !== 2'b00) begin
      errors++;
      $display("FAIL alu_commit: got wd=%h pc=%h rd=%0d nwe=%b err=%b, want 1234 40 5 1 00",
               mem_wdata, mem_pc, mem_rd, mem_rf_nwe, mem_err);
    end
  endtask

  task automatic test_load_wait();
    zero_inputs();
    ex_pc = 32'h80; ex_alu_out = 32'h100; ex_rf_wsel = 3'd1;
    ex_rd = 5'd7; ex_rf_nwe = 1'b1; ex_is_ram = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ram_ack   = (i == 3);
      ram_rdata = (i == 3) ? 32'hDEADBEEF : 32'h0;
      #1;
      checks++;
      if (stall !== (i < 3) || ram_req !== 1'b1 || ram_addr !== 32'h100 ||
          ram_we !== 1'b0) begin
        errors++;
        $display("FAIL load_comb[%0d]: got stall=%b req=%b addr=%h we=%b, want %b 1 100 0",
                 i, stall, ram_req, ram_addr, ram_we, (i < 3));
      end
      tick();
      if (i < 3) begin
        checks++;
        if (mem_rf_nwe !== 1'b0 || mem_pc !== 32'h40 || mem_err !== 2'b00) begin
          errors++;
          $display("FAIL load_hold[%0d]: got nwe=%b pc=%h err=%b, want 0 40 00",
                   i, mem_rf_nwe, mem_pc, mem_err);
        end
      end
    end
    checks++;
    if (mem_wdata !== 32'hDEADBEEF || mem_rf_nwe !== 1'b1 || mem_rd !== 5'd7 ||
        mem_pc !== 32'h80) begin
      errors++;
      $display("FAIL load_commit: got wd=%h nwe=%b rd=%0d pc=%h, want deadbeef 1 7 80",
               mem_wdata, mem_rf_nwe, mem_rd, mem_pc);
    end
  endtask

  task automatic test_store();
    zero_inputs();
    ex_pc = 32'h84; ex_alu_out = 32'h104; ex_rdata2 = 32'hA5A5A5A5;
    ex_ram_we = 1'b1; ex_is_ram = 1'b1; ram_ack = 1'b1;
    ram_rdata = 32'h11111111;
    #1;
    checks++;
    if (ram_we !== 1'b1 || ram_wdata !== 32'hA5A5A5A5 || stall !== 1'b0 ||
        ram_addr !== 32'h104) begin
      errors++;
      $display("FAIL store_comb: got we=%b wdata=%h stall=%b addr=%h, want 1 a5a5a5a5 0 104",
               ram_we, ram_wdata, stall, ram_addr);
    end
    tick();
    checks++;
    if (mem_wdata !== 32'h104 || mem_rf_nwe !== 1'b0 || mem_err !== 2'b00) begin
      errors++;
      $display("FAIL store_commit: got wd=%h nwe=%b err=%b, want 104 0 00",
               mem_wdata, mem_rf_nwe, mem_err);
    end
  endtask

  task automatic test_timeout();
    int stalls = 0;
    bit done = 0;
    zero_inputs();
    ex_pc = 32'h88; ex_alu_out = 32'h200; ex_rf_wsel = 3'd1;
    ex_rd = 5'd9; ex_rf_nwe = 1'b1; ex_is_ram = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      #1;
      if (stall === 1'b1) begin
        stalls++;
        tick();
      end else begin
        done = 1;
        checks++;
        if (ram_req !== 1'b1) begin
          errors++;
          $display("FAIL timeout_req: got req=%b, want 1", ram_req);
        end
        tick();
      end
    end
    checks++;
    if (!done || stalls != 4) begin
      errors++;
      $display("FAIL timeout_stalls: got %0d stalls (done=%b), want 4", stalls, done);
    end
    checks++;
    if (mem_err !== 2'b01 || mem_rf_nwe !== 1'b0 || mem_pc !== 32'h88) begin
      errors++;
      $display("FAIL timeout_commit: got err=%b nwe=%b pc=%h, want 01 0 88",
               mem_err, mem_rf_nwe, mem_pc);
    end
    zero_inputs();
    tick();
    checks++;
    if (mem_err !== 2'b00) begin
      errors++;
      $display("FAIL timeout_pulse: got err=%b, want 00", mem_err);
    end
  endtask

  task automatic test_ack_at_timeout();
    zero_inputs();
    ex_pc = 32'h8C; ex_alu_out = 32'h300; ex_rf_wsel = 3'd1;
    ex_rd = 5'd3; ex_rf_nwe = 1'b1; ex_is_ram = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ram_ack = 1'b1; ram_rdata = 32'hCAFEF00D;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL ackto_stall: got %b, want 0", stall);
    end
    tick();
    checks++;
    if (mem_err !== 2'b00 || mem_rf_nwe !== 1'b1 || mem_wdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL ackto_commit: got err=%b nwe=%b wd=%h, want 00 1 cafef00d",
               mem_err, mem_rf_nwe, mem_wdata);
    end
  endtask

  task automatic test_misalign();
    zero_inputs();
    ex_pc = 32'h90; ex_alu_out = 32'h102; ex_rf_wsel = 3'd1;
    ex_rd = 5'd4; ex_rf_nwe = 1'b1; ex_is_ram = 1'b1;
    #1;
    checks++;
    if (ram_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL misalign_comb: got req=%b stall=%b, want 0 0", ram_req, stall);
    end
    tick();
    checks++;
    if (mem_err !== 2'b10 || mem_rf_nwe !== 1'b0) begin
      errors++;
      $display("FAIL misalign_commit: got err=%b nwe=%b, want 10 0", mem_err, mem_rf_nwe);
    end
  endtask

  task automatic test_link();
    zero_inputs();
    ex_pc = 32'hFFFFFFFC; ex_alu_out = 32'h55; ex_rf_wsel = 3'd2;
    ex_rd = 5'd31; ex_rf_nwe = 1'b1;
    tick();
    checks++;
    if (mem_wdata !== 32'h4 || mem_rf_nwe !== 1'b1 || mem_err !== 2'b00) begin
      errors++;
      $display("FAIL link: got wd=%h nwe=%b err=%b, want 4 1 00",
               mem_wdata, mem_rf_nwe, mem_err);
    end
    ex_rf_wsel = 3'd6;
    tick();
    checks++;
    if (mem_wdata !== 32'h55) begin
      errors++;
      $display("FAIL wsel6: got wd=%h, want 55", mem_wdata);
    end
  endtask

  task automatic test_reset_wait();
    zero_inputs();
    ex_pc = 32'h94; ex_alu_out = 32'h400; ex_rf_wsel = 3'd1;
    ex_rd = 5'd2; ex_rf_nwe = 1'b1; ex_is_ram = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
    zero_inputs();
    ram_ack = 1'b1;
    tick();
    checks++;
    if ({mem_pc, mem_wdata, mem_rd, mem_rf_nwe, mem_err} !== 72'd0) begin
      errors++;
      $display("FAIL reset_wait_regs: got pc=%h wd=%h rd=%0d nwe=%b err=%b, want all 0",
               mem_pc, mem_wdata, mem_rd, mem_rf_nwe, mem_err);
    end
    resetn = 1'b1;
    ram_ack = 1'b0;
    #1;
    checks++;
    if (ram_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_comb: got req=%b stall=%b, want 0 0", ram_req, stall);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_timeout();
    test_ack_at_timeout();
    test_misalign();
    test_link();
    test_reset_wait();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
